// File: rtl/morse_pkg.sv
// Shared Morse constants and controller state encoding.
// The decoder imports the same symbol codes, so the two blocks agree on the letter format.
package morse_pkg;

    localparam logic [1:0] SYM_DOT     = 2'b01;
    localparam logic [1:0] SYM_DASH    = 2'b11;
    localparam int         MAX_SYMBOLS = 4;
    localparam int         LETTER_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        EMIT
    } state_e;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the raw key.
// Rise and fall pulses are registered, so an edge is acted on one cycle after it reaches the synchronized level.
module key_sync (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        sync1_d = key;
        sync2_d = sync1_q;
        rise_d  = sync1_q & ~sync2_q;
        fall_d  = ~sync1_q & sync2_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/morse_letter_ctrl.sv
// Times key presses against tick_en, builds the dot/dash letter code and strobes it
// to the decoder once the key has stayed released for a letter gap.
module morse_letter_ctrl
    import morse_pkg::*;
#(
    parameter int unsigned DASH_TICKS = 3,
    parameter int unsigned GAP_TICKS  = 3,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key,
    input  logic                tick_en,
    output logic [LETTER_W-1:0] letter_bits,
    output logic                letter_valid,
    output logic                letter_err,
    output logic                busy
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DASH_CNT = CNT_W'(DASH_TICKS);
    localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP_TICKS);
    localparam logic [2:0]       SYM_MAX  = 3'(MAX_SYMBOLS);

    logic key_rise, key_fall;

    key_sync u_key_sync (
        .clk   (clk),
        .reset (reset),
        .key   (key),
        .rise  (key_rise),
        .fall  (key_fall)
    );

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LETTER_W-1:0] shreg_q, shreg_d;
    logic [2:0]          sym_cnt_q, sym_cnt_d;
    logic                ovf_q, ovf_d;
    logic [LETTER_W-1:0] letter_bits_q, letter_bits_d;
    logic                letter_valid_q, letter_valid_d;
    logic                letter_err_q, letter_err_d;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CNT_W-1:0]    cnt_eff;
    logic [1:0]          symbol;

    // Output registers are loaded on the edge entering EMIT so the strobe and the code appear together.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shreg_d        = shreg_q;
        sym_cnt_d      = sym_cnt_q;
        ovf_d          = ovf_q;
        letter_bits_d  = letter_bits_q;
        letter_err_d   = letter_err_q;
        letter_valid_d = 1'b0;
        cnt_inc        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        cnt_eff        = tick_en ? cnt_inc : cnt_q;
        symbol         = SYM_DOT;

        unique case (state_q)
            IDLE: begin
                if (key_rise) begin
                    cnt_d   = '0;
                    state_d = PRESS;
                end
            end
            PRESS: begin
                cnt_d = cnt_eff;
                if (key_fall) begin
                    symbol = (cnt_eff >= DASH_CNT) ? SYM_DASH : SYM_DOT;
                    if (sym_cnt_q < SYM_MAX) begin
                        shreg_d   = {shreg_q[LETTER_W-3:0], symbol};
                        sym_cnt_d = sym_cnt_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (key_rise) begin
                    cnt_d   = '0;
                    state_d = PRESS;
                end else if (tick_en) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == GAP_CNT) begin
                        state_d        = EMIT;
                        letter_valid_d = 1'b1;
                        letter_bits_d  = ovf_q ? '0 : shreg_q;
                        letter_err_d   = ovf_q;
                    end
                end
            end
            EMIT: begin
                shreg_d   = '0;
                sym_cnt_d = '0;
                ovf_d     = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shreg_q        <= '0;
            sym_cnt_q      <= '0;
            ovf_q          <= 1'b0;
            letter_bits_q  <= '0;
            letter_valid_q <= 1'b0;
            letter_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shreg_q        <= shreg_d;
            sym_cnt_q      <= sym_cnt_d;
            ovf_q          <= ovf_d;
            letter_bits_q  <= letter_bits_d;
            letter_valid_q <= letter_valid_d;
            letter_err_q   <= letter_err_d;
        end
    end

    assign letter_bits  = letter_bits_q;
    assign letter_valid = letter_valid_q;
    assign letter_err   = letter_err_q;
    assign busy         = (state_q == PRESS) || (state_q == GAP);

endmodule

// File: tb/tb_morse_letter_ctrl.sv
// Directed bench for morse_letter_ctrl: keys letters in whole tick periods (4 cycles, tick in the last)
// and checks the strobed codes, error flag, busy and reset behaviour against hand-computed values.
module tb_morse_letter_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       key;
    logic       tick_en;
    logic [7:0] letter_bits;
    logic       letter_valid;
    logic       letter_err;
    logic       busy;

    int checkCount  = 0;
    int errorCount  = 0;
    int strobeCount = 0;
    int backToBack  = 0;
    int startCount  = 0;
    logic       prevValid = 1'b0;
    logic [7:0] lastBits  = 8'h00;
    logic       lastErr   = 1'b0;

    morse_letter_ctrl #(
        .DASH_TICKS (3),
        .GAP_TICKS  (3),
        .CNT_W      (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key          (key),
        .tick_en      (tick_en),
        .letter_bits  (letter_bits),
        .letter_valid (letter_valid),
        .letter_err   (letter_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Strobe monitor on the falling edge: counts letters, keeps the last code and catches back-to-back strobes.
    always @(negedge clk) begin
        if (letter_valid) begin
            strobeCount = strobeCount + 1;
            lastBits    = letter_bits;
            lastErr     = letter_err;
            if (prevValid) backToBack = backToBack + 1;
        end
        prevValid = letter_valid;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (actual !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One clock cycle: inputs change on the falling edge, the task returns just after the rising edge.
    task automatic driveCycle(input logic k, input logic t);
        @(negedge clk);
        key     = k;
        tick_en = t;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic k, input int nTicks);
        for (int i = 0; i < nTicks; i++) begin
            driveCycle(k, 1'b0);
            driveCycle(k, 1'b0);
            driveCycle(k, 1'b0);
            driveCycle(k, 1'b1);
        end
    endtask

    task automatic sendSymbol(input int pressTicks, input int gapTicks);
        applyStimulus(1'b1, pressTicks);
        applyStimulus(1'b0, gapTicks);
    endtask

    task automatic checkLetter(input string tag, input logic [7:0] bits, input logic err);
        for (int i = 0; i < 4; i++) driveCycle(1'b0, 1'b0);
        checkOutput({tag, "_strobes"}, strobeCount - startCount, 1);
        checkOutput({tag, "_bits"}, lastBits, bits);
        checkOutput({tag, "_err"}, lastErr, err);
        checkOutput({tag, "_held"}, letter_bits, bits);
    endtask

    initial begin
        reset   = 1'b0;
        key     = 1'b0;
        tick_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_bits", letter_bits, 8'h00);
        checkOutput("rst_valid", letter_valid, 1'b0);
        checkOutput("rst_err", letter_err, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        reset = 1'b1;
        driveCycle(1'b0, 1'b0);

        // Single dot: strobe exactly on the edge where the third gap tick lands.
        startCount = strobeCount;
        applyStimulus(1'b1, 1);
        checkOutput("dot_busy_press", busy, 1'b1);
        applyStimulus(1'b0, 2);
        checkOutput("dot_busy_gap", busy, 1'b1);
        checkOutput("dot_no_early", letter_valid, 1'b0);
        applyStimulus(1'b0, 1);
        checkOutput("dot_valid_now", letter_valid, 1'b1);
        checkOutput("dot_bits_now", letter_bits, 8'h01);
        driveCycle(1'b0, 1'b0);
        checkOutput("dot_valid_drop", letter_valid, 1'b0);
        checkOutput("dot_busy_idle", busy, 1'b0);
        checkLetter("dot", 8'h01, 1'b0);

        // Dot, dash(4) -> 0000_0111.
        startCount = strobeCount;
        sendSymbol(1, 1);
        sendSymbol(4, 3);
        checkLetter("dot_dash", 8'h07, 1'b0);

        // Dash(3), dash(4), dot(2), dash(3) -> 1111_0111.
        startCount = strobeCount;
        sendSymbol(3, 1);
        sendSymbol(4, 1);
        sendSymbol(2, 1);
        sendSymbol(3, 3);
        checkLetter("ddtd", 8'hF7, 1'b0);

        // Two-tick press whose release coincides with a tick: tick counts first, so it is a dash.
        startCount = strobeCount;
        applyStimulus(1'b1, 2);
        driveCycle(1'b0, 1'b0);
        driveCycle(1'b0, 1'b0);
        driveCycle(1'b0, 1'b1);
        driveCycle(1'b0, 1'b0);
        applyStimulus(1'b0, 3);
        checkLetter("tick_on_fall", 8'h03, 1'b0);

        // Five dots overflow the letter; the following single dot is clean.
        startCount = strobeCount;
        for (int i = 0; i < 4; i++) sendSymbol(1, 1);
        sendSymbol(1, 3);
        checkLetter("ovf", 8'h00, 1'b1);
        startCount = strobeCount;
        sendSymbol(1, 3);
        checkLetter("after_ovf", 8'h01, 1'b0);

        // Rise acted on in the same cycle the gap count would reach 3: no strobe, dash joins the letter.
        startCount = strobeCount;
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 2);
        driveCycle(1'b0, 1'b0);
        driveCycle(1'b1, 1'b0);
        driveCycle(1'b1, 1'b0);
        driveCycle(1'b1, 1'b1);
        checkOutput("race_no_strobe", strobeCount - startCount, 0);
        checkOutput("race_busy", busy, 1'b1);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 3);
        checkLetter("race", 8'h07, 1'b0);

        // Reset mid-press, key held through release; the press is retimed from the new rise.
        startCount = strobeCount;
        applyStimulus(1'b1, 2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midrst_bits", letter_bits, 8'h00);
        checkOutput("midrst_valid", letter_valid, 1'b0);
        checkOutput("midrst_err", letter_err, 1'b0);
        checkOutput("midrst_busy", busy, 1'b0);
        driveCycle(1'b1, 1'b0);
        driveCycle(1'b1, 1'b0);
        checkOutput("midrst_hold_bits", letter_bits, 8'h00);
        reset = 1'b1;
        driveCycle(1'b1, 1'b0);
        driveCycle(1'b1, 1'b0);
        checkOutput("postrst_not_busy", busy, 1'b0);
        driveCycle(1'b1, 1'b0);
        checkOutput("postrst_busy", busy, 1'b1);
        driveCycle(1'b1, 1'b1);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 3);
        checkLetter("postrst", 8'h01, 1'b0);

        checkOutput("no_back_to_back", backToBack, 0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
